stream_demux: RTL

//  1-to-NUM_OUT packet demultiplexer; the steering counterpart to the 2:1 mux.

---
 rtl/demux_pkg.sv | 18 +
 rtl/stream_demux_hold.sv | 58 +++++
 rtl/stream_demux.sv | 129 ++++++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared types for the stream demultiplexer: FSM state encoding and drop-counter width.
// The drop counter exists only when DEMUX_DROP_CNT_EN is defined.
package demux_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT  = 2'd1,
        DROP = 2'd2
    } demux_state_e;

    localparam int CNT_W = 16;

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/stream_demux_hold.sv
// One-entry output holding register: payload, last flag and one-hot valid.
// A load replaces the entry; an accept without a load empties it.
module stream_demux_hold
    import demux_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NUM_OUT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DATA_W-1:0]  load_data,
    input  logic               load_last,
    input  logic [NUM_OUT-1:0] load_onehot,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_last,
    output logic [NUM_OUT-1:0] out_valid,
    output logic               accept
);

    logic [DATA_W-1:0]  data_q, data_d;
    logic               last_q, last_d;
    logic [NUM_OUT-1:0] valid_q, valid_d;

    assign accept = |(valid_q & out_ready);

    // A load on the same cycle as an accept refills without a bubble.
    always_comb begin
        data_d  = data_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (load) begin
            data_d  = load_data;
            last_d  = load_last;
            valid_d = load_onehot;
        end else if (accept) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= '0;
        end else begin
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_last  = last_q;
    assign out_valid = valid_q;

endmodule

// File: rtl/stream_demux.sv
// 1-to-NUM_OUT packet demultiplexer: the first beat's in_sel locks the destination for the packet.
// Define DEMUX_DROP_CNT_EN to add the saturating drop_count output.
module stream_demux
    import demux_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_last,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_last,
    output logic [NUM_OUT-1:0] out_valid,
    input  logic [NUM_OUT-1:0] out_ready
`ifdef DEMUX_DROP_CNT_EN
    ,
    output logic [CNT_W-1:0]   drop_count
`endif
);

    // Valid/ready: a beat moves on in_valid && in_ready, or out_valid[i] && out_ready[i].
    // in_ready never depends on in_valid; a held beat stays stable until accepted.

    demux_state_e       state_q, state_d;
    logic [SEL_W-1:0]   dest_q, dest_d;
    logic [SEL_W-1:0]   load_dest;
    logic [NUM_OUT-1:0] load_onehot;
    logic               out_accept;
    logic               in_fire;
    logic               sel_ok;
    logic               load;
    logic               drop_first;

    assign in_ready = (state_q == DROP) || ~|out_valid || out_accept;
    assign in_fire  = in_valid && in_ready;
    assign sel_ok   = int'(in_sel) < NUM_OUT;

    always_comb begin
        state_d    = state_q;
        dest_d     = dest_q;
        load       = 1'b0;
        load_dest  = dest_q;
        drop_first = 1'b0;
        if (in_fire) begin
            case (state_q)
                IDLE: begin
                    if (sel_ok) begin
                        load      = 1'b1;
                        load_dest = in_sel;
                        dest_d    = in_sel;
                        state_d   = in_last ? IDLE : PKT;
                    end else begin
                        drop_first = 1'b1;
                        state_d    = in_last ? IDLE : DROP;
                    end
                end
                PKT: begin
                    load = 1'b1;
                    if (in_last) state_d = IDLE;
                end
                DROP: begin
                    if (in_last) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        load_onehot = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            load_onehot[i] = (load_dest == SEL_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dest_q  <= '0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
        end
    end

    stream_demux_hold #(
        .DATA_W  (DATA_W),
        .NUM_OUT (NUM_OUT)
    ) u_hold (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .load_data   (in_data),
        .load_last   (in_last),
        .load_onehot (load_onehot),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_valid   (out_valid),
        .accept      (out_accept)
    );

`ifdef DEMUX_DROP_CNT_EN
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // Counted once per dropped packet, on its first beat.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_first) drop_cnt_d = sat_inc(drop_cnt_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_cnt_q <= '0;
        else     drop_cnt_q <= drop_cnt_d;
    end

    assign drop_count = drop_cnt_q;
`else
    logic unused_drop_first;
    assign unused_drop_first = drop_first;
`endif

endmodule
